rv32i_regfile_sb: RTL and testbench
===================================

# rv32i_regfile_sb

Parametrised general-purpose register file for the RV32I/RV32E core, the successor to the fixed two-read/one-write file. It adds a configurable register count, a configurable number of read ports, and optional write-to-read bypass. A per-register pending-write scoreboard lets the decode stage detect RAW hazards against in-flight producers. It sits between decode (read/claim) and writeback (write) in the pipeline.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; 16 (RV32E) or 32
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array contents only
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*5  read addresses; port i uses bits [5i+4:5i]
- rd_data  out  NRD*XLEN  read data; port i uses bits [XLEN*i+XLEN-1:XLEN*i]
- rd_busy  out  NRD  1 = register addressed by port i has an outstanding claimed write
- wr_en  in  1  writeback strobe
- wr_addr  in  5  writeback destination
- wr_data  in  XLEN  writeback value
- claim_en  in  1  decode issued an instruction that will write claim_addr
- claim_addr  in  5  destination being claimed
- flush  in  1  pipeline flush; clears all pending bits
- pending_cnt  out  $clog2(NREGS)+1  number of registers currently pending

## Operation
- Storage: NREGS x XLEN array plus NREGS-bit pending vector. Register 0 is hardwired: reads 0, never pending, writes and claims to it are ignored.
- Out-of-range addresses (addr >= NREGS): reads return 0 with busy 0; writes and claims are ignored.
- Write: when wr_en, wr_addr valid and nonzero, regs[wr_addr] <= wr_data, and pending[wr_addr] is cleared.
- Claim: when claim_en, claim_addr valid and nonzero, and flush is 0, pending[claim_addr] is set.
- Claim and write to the same register in the same cycle: the data is written and the pending bit ends up set, because the claim belongs to a newer producer.
- Flush: all pending bits are cleared. A write in the same cycle still commits; a claim in the same cycle is dropped.
- Read port i, combinational:
  - If BYPASS=1, wr_en=1, wr_addr==rd_addr_i, the address is nonzero and in range, and rst=1: rd_data_i = wr_data and rd_busy_i = 0.
  - Otherwise: rd_data_i = regs[rd_addr_i] and rd_busy_i = pending[rd_addr_i].
- A same-cycle claim does not affect the current-cycle rd_busy; it becomes visible next cycle.
- pending_cnt is the registered population count of the pending vector. It is updated on the same edge as the vector and equals popcount(pending) at all times.
- Reset (rst=0 at posedge): all registers become 0, all pending bits become 0, pending_cnt becomes 0. Writes, claims and flush in that cycle are ignored.
- Reset mid-operation discards outstanding claims; no state survives.

## Timing
- Write-to-read latency through the array is 1 cycle, so the value is visible the cycle after wr_en.
- With BYPASS=1 the write-to-read latency is 0 cycles, via the combinational path.
- Claim-to-busy latency is 1 cycle; write-to-busy-clear is 1 cycle, or 0 via bypass.
- Flush takes effect on the next edge; rd_busy reads all 0 the following cycle.
- Reset values after the reset edge: every rd_data = 0, every rd_busy = 0, pending_cnt = 0.
- No handshake backpressure exists: every request is accepted in the cycle presented.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst=0 for one edge -> reading x5 returns 0, rd_busy=0, pending_cnt=0.
- x0 protection: claim x0, then write 0x1234 to x0 -> the read returns 0, busy 0, pending_cnt 0.
- Scoreboard:
  - Claim x7 at cycle 0 -> cycle 1 read of x7 has busy=1 and pending_cnt=1.
  - Write 0xA5A5A5A5 to x7 at cycle 3 -> with BYPASS=1 the same-cycle read gives 0xA5A5A5A5 with busy 0; cycle 4 gives busy 0 and pending_cnt 0.
- Simultaneous claim+write on x9 with value 0x42 -> next cycle x9 = 0x42, busy=1, pending_cnt=1.
- Flush: claim x1, x2 and x3 on successive cycles, then assert flush together with a claim of x4 -> next cycle pending_cnt=0 and x4 is not busy.
- Parameter sweep:
  - NREGS=16, NRD=3, BYPASS=0: write to x20 is ignored (read returns 0).
  - With the same parameters, write 0x77 to x15 -> the same-cycle read returns the old value 0, and the next cycle returns 0x77 on all three ports.

Source files
------------

// File: rtl/rv32i_regfile_sb_if.sv
// rv32i_regfile_sb_if: decode/writeback bundle for the scoreboarded register file
interface rv32i_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  logic [NRD*5-1:0]       rd_addr;
  logic [NRD*XLEN-1:0]    rd_data;
  logic [NRD-1:0]         rd_busy;
  logic                   wr_en;
  logic [4:0]             wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   claim_en;
  logic [4:0]             claim_addr;
  logic                   flush;
  logic [$clog2(NREGS):0] pending_cnt;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
    input  rd_data, rd_busy, pending_cnt
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
    output rd_data, rd_busy, pending_cnt
  );
endinterface

// File: rtl/rv32i_regfile_sb.sv
// rv32i_regfile_sb: parametrised register file with per-register pending-write scoreboard
module rv32i_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  rv32i_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;
  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    pending;
  logic [NREGS-1:0]    pending_nx;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nx;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_ok;
  logic                claim_ok;

  // x0 and addresses beyond the implemented file are never stored or tracked
  function automatic logic valid(input logic [4:0] a);
    return a != 5'd0 && (a >> AW) == 5'd0;
  endfunction

  assign wr_ok    = bus.wr_en && valid(bus.wr_addr);
  assign claim_ok = bus.claim_en && valid(bus.claim_addr) && !bus.flush;

  // next scoreboard state: a claim outranks a same-cycle write, flush drops everything
  always_comb begin
    pending_nx = bus.flush ? '0 : pending;
    if (wr_ok) pending_nx[bus.wr_addr[AW-1:0]] = 1'b0;
    if (claim_ok) pending_nx[bus.claim_addr[AW-1:0]] = 1'b1;
    cnt_nx = '0;
    for (int k = 0; k < NREGS; k++) cnt_nx = cnt_nx + CW'(pending_nx[k]);
  end

  // array, scoreboard and its population count all move on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      cnt     <= '0;
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      pending <= pending_nx;
      cnt     <= cnt_nx;
      if (wr_ok) regs[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
  end

  // per-port combinational read, forwarding the writeback value when enabled
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [4:0] a;
      logic       hit;
      a   = bus.rd_addr[5*i +: 5];
      hit = BYPASS != 0 && bus.wr_en && bus.wr_addr == a && rst;
      rd_data[XLEN*i +: XLEN] = !valid(a) ? '0 : hit ? bus.wr_data : regs[a[AW-1:0]];
      rd_busy[i] = valid(a) && !hit && pending[a[AW-1:0]];
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.rd_busy     = rd_busy;
  assign bus.pending_cnt = cnt;
endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// tb_rv32i_regfile_sb: directed and random checks of two register file configurations against a reference model
module tb_rv32i_regfile_sb;
  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        flush;
  logic [4:0]  ra [4];
  int checks = 0;
  int errors = 0;

  rv32i_regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) a_if ();
  rv32i_regfile_sb_if #(.XLEN(32), .NREGS(16), .NRD(3)) b_if ();

  rv32i_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  rv32i_regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  assign a_if.rd_addr    = {ra[1], ra[0]};
  assign a_if.wr_en      = wr_en;
  assign a_if.wr_addr    = wr_addr;
  assign a_if.wr_data    = wr_data;
  assign a_if.claim_en   = claim_en;
  assign a_if.claim_addr = claim_addr;
  assign a_if.flush      = flush;
  assign b_if.rd_addr    = {ra[2], ra[1], ra[0]};
  assign b_if.wr_en      = wr_en;
  assign b_if.wr_addr    = wr_addr;
  assign b_if.wr_data    = wr_data;
  assign b_if.claim_en   = claim_en;
  assign b_if.claim_addr = claim_addr;
  assign b_if.flush      = flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: index 0 = 32 regs with bypass, index 1 = 16 regs without
  int          m_nregs [2] = '{32, 16};
  bit          m_byp   [2] = '{1'b1, 1'b0};
  logic [31:0] m_regs  [2][32];
  bit          m_pend  [2][32];

  function automatic bit m_ok(input int k, input int a);
    return a != 0 && a < m_nregs[k];
  endfunction

  function automatic void m_read(input int k, input int a, output logic [31:0] d, output logic b);
    if (!m_ok(k, a)) begin
      d = 0;
      b = 0;
    end else if (m_byp[k] && wr_en && int'(wr_addr) == a && rst) begin
      d = wr_data;
      b = 0;
    end else begin
      d = m_regs[k][a];
      b = m_pend[k][a];
    end
  endfunction

  function automatic int m_count(input int k);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_pend[k][r]);
    return n;
  endfunction

  task automatic m_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[k][r] = 0;
          m_pend[k][r] = 0;
        end
      end else begin
        if (wr_en && m_ok(k, wr_addr)) begin
          m_regs[k][wr_addr] = wr_data;
          m_pend[k][wr_addr] = 0;
        end
        if (flush) for (int r = 0; r < 32; r++) m_pend[k][r] = 0;
        else if (claim_en && m_ok(k, claim_addr)) m_pend[k][claim_addr] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] d;
    logic        b;
    for (int p = 0; p < 2; p++) begin
      m_read(0, ra[p], d, b);
      chk($sformatf("a_data%0d", p), a_if.rd_data[32*p +: 32], d);
      chk($sformatf("a_busy%0d", p), a_if.rd_busy[p], b);
    end
    for (int p = 0; p < 3; p++) begin
      m_read(1, ra[p], d, b);
      chk($sformatf("b_data%0d", p), b_if.rd_data[32*p +: 32], d);
      chk($sformatf("b_busy%0d", p), b_if.rd_busy[p], b);
    end
    chk("a_cnt", a_if.pending_cnt, m_count(0));
    chk("b_cnt", b_if.pending_cnt, m_count(1));
  endtask

  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst      = 1'b1;
    wr_en    = 1'b0;
    claim_en = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    idle();
    rst        = 1'b0;
    wr_addr    = 0;
    wr_data    = 0;
    claim_addr = 0;
    for (int p = 0; p < 4; p++) ra[p] = 0;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    idle();
    cyc();
    // reset wipes a written register
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cyc();
    idle();
    rst = 0; ra[0] = 5;
    cyc();
    rst = 1;
    #1;
    chk("reset_data", a_if.rd_data[31:0], 0);
    chk("reset_busy", a_if.rd_busy[0], 0);
    chk("reset_cnt", a_if.pending_cnt, 0);
    cyc();
    // x0 ignores claims and writes
    claim_en = 1; claim_addr = 0;
    cyc();
    idle();
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    cyc();
    idle();
    ra[0] = 0;
    #1;
    chk("x0_data", a_if.rd_data[31:0], 0);
    chk("x0_busy", a_if.rd_busy[0], 0);
    chk("x0_cnt", a_if.pending_cnt, 0);
    cyc();
    // claim x7, then write it back with bypass
    claim_en = 1; claim_addr = 7; ra[0] = 7;
    cyc();
    idle();
    #1;
    chk("claim_busy", a_if.rd_busy[0], 1);
    chk("claim_cnt", a_if.pending_cnt, 1);
    cyc();
    cyc();
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    #1;
    chk("bypass_data", a_if.rd_data[31:0], 32'hA5A5A5A5);
    chk("bypass_busy", a_if.rd_busy[0], 0);
    cyc();
    idle();
    #1;
    chk("wb_busy", a_if.rd_busy[0], 0);
    chk("wb_cnt", a_if.pending_cnt, 0);
    chk("wb_data", a_if.rd_data[31:0], 32'hA5A5A5A5);
    cyc();
    // claim and write of x9 together: newer producer keeps it pending
    claim_en = 1; claim_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h42; ra[0] = 3;
    cyc();
    idle();
    ra[0] = 9;
    #1;
    chk("cw_data", a_if.rd_data[31:0], 32'h42);
    chk("cw_busy", a_if.rd_busy[0], 1);
    chk("cw_cnt", a_if.pending_cnt, 1);
    cyc();
    // flush beats a same-cycle claim
    for (int r = 1; r <= 3; r++) begin
      claim_en = 1; claim_addr = 5'(r);
      cyc();
    end
    claim_en = 1; claim_addr = 4; flush = 1; ra[0] = 4;
    #1;
    chk("preflush_cnt", a_if.pending_cnt, 4);
    cyc();
    idle();
    #1;
    chk("flush_cnt", a_if.pending_cnt, 0);
    chk("flush_busy", a_if.rd_busy[0], 0);
    cyc();
    // small file without bypass: x20 out of range, x15 latency
    wr_en = 1; wr_addr = 20; wr_data = 32'h99;
    cyc();
    idle();
    ra[0] = 20;
    #1;
    chk("oor_data", b_if.rd_data[31:0], 0);
    chk("oor_busy", b_if.rd_busy[0], 0);
    cyc();
    wr_en = 1; wr_addr = 15; wr_data = 32'h77;
    for (int p = 0; p < 3; p++) ra[p] = 15;
    #1;
    chk("nobyp_old", b_if.rd_data[31:0], 0);
    cyc();
    idle();
    #1;
    for (int p = 0; p < 3; p++) chk($sformatf("nobyp_new%0d", p), b_if.rd_data[32*p +: 32], 32'h77);
    cyc();
    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst        = $urandom_range(0, 39) != 0;
      wr_en      = $urandom_range(0, 1) == 1;
      wr_addr    = 5'($urandom_range(0, 31));
      wr_data    = $urandom;
      claim_en   = $urandom_range(0, 2) != 0;
      claim_addr = $urandom_range(0, 3) == 0 ? wr_addr : 5'($urandom_range(0, 31));
      flush      = $urandom_range(0, 15) == 0;
      for (int p = 0; p < 3; p++) ra[p] = $urandom_range(0, 3) == 0 ? wr_addr : 5'($urandom_range(0, 31));
      cyc();
    end
    idle();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
